// File: rtl/lector_tarjeta.sv
// Card reader front end: debounces card insertion, shifts in the serial card number, hands it off and ejects the card.
// Latency: card number valid the cycle after the last accepted bit; every output is registered.
// Backpressure: none. The controller holds the block in ENTREGA until it raises fin.
// Ports: clk, reset (sync, active-low), sensor_tarjeta, dato_serial, bit_valido, fin ->
//        tarjeta_recibida, numero_tarjeta[NUM_BITS], expulsar_tarjeta, error_lectura (1-cycle pulse).
module lector_tarjeta #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NUM_BITS        = 16,
    parameter int TIMEOUT         = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sensor_tarjeta,
    input  logic                dato_serial,
    input  logic                bit_valido,
    input  logic                fin,
    output logic                tarjeta_recibida,
    output logic [NUM_BITS-1:0] numero_tarjeta,
    output logic                expulsar_tarjeta,
    output logic                error_lectura
);

    localparam logic [2:0] ESPERA     = 3'd0;
    localparam logic [2:0] ANTIREBOTE = 3'd1;
    localparam logic [2:0] LECTURA    = 3'd2;
    localparam logic [2:0] ENTREGA    = 3'd3;
    localparam logic [2:0] EXPULSION  = 3'd4;

    // Each counter is wide enough to hold its terminal value itself.
    localparam int RW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(NUM_BITS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [RW-1:0] REB_FIN = RW'(DEBOUNCE_CYCLES);
    localparam logic [BW-1:0] BIT_FIN = BW'(NUM_BITS);
    localparam logic [TW-1:0] INA_FIN = TW'(TIMEOUT);

    logic [2:0]    estado;
    logic [RW-1:0] cnt_rebote;
    logic [BW-1:0] cnt_bits;
    logic [TW-1:0] cnt_inactivo;

    // Incremented copies used to detect the terminal count on the same edge
    // that would reach it. The counters never sit at their terminal value,
    // so these cannot wrap.
    logic [RW-1:0] rebote_sig;
    logic [BW-1:0] bits_sig;
    logic [TW-1:0] inactivo_sig;

    assign rebote_sig   = cnt_rebote + 1'b1;
    assign bits_sig     = cnt_bits + 1'b1;
    assign inactivo_sig = cnt_inactivo + 1'b1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado           <= ESPERA;
            cnt_rebote       <= '0;
            cnt_bits         <= '0;
            cnt_inactivo     <= '0;
            numero_tarjeta   <= '0;
            tarjeta_recibida <= 1'b0;
            expulsar_tarjeta <= 1'b0;
            error_lectura    <= 1'b0;
        end else begin
            // Default low so an error can only ever last one cycle.
            error_lectura <= 1'b0;
            case (estado)
                ESPERA: begin
                    if (sensor_tarjeta) begin
                        estado     <= ANTIREBOTE;
                        cnt_rebote <= RW'(1);
                    end
                end

                ANTIREBOTE: begin
                    if (!sensor_tarjeta) begin
                        // Bounce: silently start over.
                        estado     <= ESPERA;
                        cnt_rebote <= '0;
                    end else if (rebote_sig >= REB_FIN) begin
                        estado         <= LECTURA;
                        cnt_rebote     <= '0;
                        cnt_bits       <= '0;
                        cnt_inactivo   <= '0;
                        numero_tarjeta <= '0;
                    end else begin
                        cnt_rebote <= rebote_sig;
                    end
                end

                LECTURA: begin
                    if (!sensor_tarjeta) begin
                        // Card pulled mid-read wins over a coincident bit.
                        estado         <= ESPERA;
                        error_lectura  <= 1'b1;
                        cnt_bits       <= '0;
                        cnt_inactivo   <= '0;
                        numero_tarjeta <= '0;
                    end else if (bit_valido) begin
                        numero_tarjeta <= {numero_tarjeta[NUM_BITS-2:0], dato_serial};
                        cnt_inactivo   <= '0;
                        if (bits_sig == BIT_FIN) begin
                            estado           <= ENTREGA;
                            cnt_bits         <= '0;
                            tarjeta_recibida <= 1'b1;
                        end else begin
                            cnt_bits <= bits_sig;
                        end
                    end else if (inactivo_sig == INA_FIN) begin
                        estado           <= EXPULSION;
                        error_lectura    <= 1'b1;
                        expulsar_tarjeta <= 1'b1;
                        cnt_bits         <= '0;
                        cnt_inactivo     <= '0;
                    end else begin
                        cnt_inactivo <= inactivo_sig;
                    end
                end

                ENTREGA: begin
                    // A finished transaction takes precedence: the card is
                    // ejected and the sensor check moves to EXPULSION.
                    if (fin) begin
                        estado           <= EXPULSION;
                        tarjeta_recibida <= 1'b0;
                        expulsar_tarjeta <= 1'b1;
                    end else if (!sensor_tarjeta) begin
                        estado           <= ESPERA;
                        tarjeta_recibida <= 1'b0;
                        error_lectura    <= 1'b1;
                    end
                end

                EXPULSION: begin
                    if (!sensor_tarjeta) begin
                        estado           <= ESPERA;
                        expulsar_tarjeta <= 1'b0;
                    end
                end

                default: begin
                    estado           <= ESPERA;
                    tarjeta_recibida <= 1'b0;
                    expulsar_tarjeta <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lector_tarjeta.sv
module tb_lector_tarjeta;

    logic        clk = 1'b0;
    logic        reset;
    logic        sensor_tarjeta;
    logic        dato_serial;
    logic        bit_valido;
    logic        fin;
    logic        tarjeta_recibida;
    logic [15:0] numero_tarjeta;
    logic        expulsar_tarjeta;
    logic        error_lectura;

    int total = 0;
    int bad   = 0;
    int err_pulsos = 0;

    localparam logic [2:0] S_ESPERA     = 3'd0;
    localparam logic [2:0] S_ANTIREBOTE = 3'd1;
    localparam logic [2:0] S_LECTURA    = 3'd2;
    localparam logic [2:0] S_ENTREGA    = 3'd3;
    localparam logic [2:0] S_EXPULSION  = 3'd4;

    lector_tarjeta #(.DEBOUNCE_CYCLES(4), .NUM_BITS(16), .TIMEOUT(32)) dut (
        .clk              (clk),
        .reset            (reset),
        .sensor_tarjeta   (sensor_tarjeta),
        .dato_serial      (dato_serial),
        .bit_valido       (bit_valido),
        .fin              (fin),
        .tarjeta_recibida (tarjeta_recibida),
        .numero_tarjeta   (numero_tarjeta),
        .expulsar_tarjeta (expulsar_tarjeta),
        .error_lectura    (error_lectura)
    );

    always #5 clk = ~clk;

    // Outputs change only on rising edges, so one sample per falling edge
    // counts each high cycle of the error pulse exactly once.
    always @(negedge clk) if (error_lectura === 1'b1) err_pulsos++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic insertar();
        sensor_tarjeta = 1'b1;
        repeat (4) tick();
    endtask

    task automatic enviar_bits(input logic [15:0] valor, input int n);
        for (int i = 0; i < n; i++) begin
            bit_valido  = 1'b1;
            dato_serial = valor[15-i];
            tick();
        end
        bit_valido  = 1'b0;
        dato_serial = 1'b0;
    endtask

    initial begin
        int e0;
        reset = 1'b0; sensor_tarjeta = 1'b0; dato_serial = 1'b0;
        bit_valido = 1'b0; fin = 1'b0;
        repeat (3) tick();
        chk("rst_estado", 32'(dut.estado), 32'(S_ESPERA));
        chk("rst_recibida", 32'(tarjeta_recibida), 32'd0);
        chk("rst_numero", 32'(numero_tarjeta), 32'd0);
        chk("rst_expulsar", 32'(expulsar_tarjeta), 32'd0);
        chk("rst_error", 32'(error_lectura), 32'd0);
        reset = 1'b1;
        tick();

        // Stray fin while idle.
        fin = 1'b1;
        repeat (3) tick();
        chk("fin_espera_estado", 32'(dut.estado), 32'(S_ESPERA));
        chk("fin_espera_salidas", {29'd0, tarjeta_recibida, expulsar_tarjeta, error_lectura}, 32'd0);
        fin = 1'b0;

        // Normal transaction with 0xA5C3.
        e0 = err_pulsos;
        sensor_tarjeta = 1'b1;
        repeat (3) tick();
        chk("norm_antirebote", 32'(dut.estado), 32'(S_ANTIREBOTE));
        tick();
        chk("norm_lectura", 32'(dut.estado), 32'(S_LECTURA));
        fin = 1'b1;                                // stray fin during the read
        enviar_bits(16'hA5C3, 15);
        chk("norm_15bits_recibida", 32'(tarjeta_recibida), 32'd0);
        chk("norm_15bits_estado", 32'(dut.estado), 32'(S_LECTURA));
        fin = 1'b0;
        enviar_bits(16'hA5C3 << 15, 1);            // last bit is bit0 of A5C3 = 1
        chk("norm_recibida", 32'(tarjeta_recibida), 32'd1);
        chk("norm_numero", 32'(numero_tarjeta), 32'hA5C3);
        repeat (3) tick();
        chk("norm_entrega_espera", 32'(dut.estado), 32'(S_ENTREGA));
        chk("norm_entrega_recibida", 32'(tarjeta_recibida), 32'd1);
        fin = 1'b1;
        tick();
        fin = 1'b0;
        chk("norm_fin_recibida", 32'(tarjeta_recibida), 32'd0);
        chk("norm_fin_expulsar", 32'(expulsar_tarjeta), 32'd1);
        repeat (2) tick();
        chk("norm_expulsar_mantiene", 32'(expulsar_tarjeta), 32'd1);
        sensor_tarjeta = 1'b0;
        tick();
        chk("norm_fin_expulsar_0", 32'(expulsar_tarjeta), 32'd0);
        chk("norm_vuelta_espera", 32'(dut.estado), 32'(S_ESPERA));
        chk("norm_numero_retiene", 32'(numero_tarjeta), 32'hA5C3);
        chk("norm_sin_error", 32'(err_pulsos - e0), 32'd0);

        // Bounce: three high samples then low.
        e0 = err_pulsos;
        sensor_tarjeta = 1'b1;
        repeat (3) tick();
        sensor_tarjeta = 1'b0;
        tick();
        chk("rebote_estado", 32'(dut.estado), 32'(S_ESPERA));
        tick();
        chk("rebote_sin_error", 32'(err_pulsos - e0), 32'd0);
        chk("rebote_numero_retiene", 32'(numero_tarjeta), 32'hA5C3);

        // Card pulled after 7 bits, coincident with a valid bit.
        e0 = err_pulsos;
        insertar();
        enviar_bits(16'hFFFF, 7);
        sensor_tarjeta = 1'b0;
        bit_valido = 1'b1; dato_serial = 1'b1;
        tick();
        bit_valido = 1'b0; dato_serial = 1'b0;
        chk("retiro_error", 32'(error_lectura), 32'd1);
        chk("retiro_estado", 32'(dut.estado), 32'(S_ESPERA));
        chk("retiro_recibida", 32'(tarjeta_recibida), 32'd0);
        repeat (3) tick();
        chk("retiro_un_pulso", 32'(err_pulsos - e0), 32'd1);

        // Timeout after 5 bits.
        e0 = err_pulsos;
        insertar();
        enviar_bits(16'h8000, 5);
        repeat (31) tick();
        chk("timeout_31_estado", 32'(dut.estado), 32'(S_LECTURA));
        chk("timeout_31_error", 32'(err_pulsos - e0), 32'd0);
        tick();
        chk("timeout_error", 32'(error_lectura), 32'd1);
        chk("timeout_expulsar", 32'(expulsar_tarjeta), 32'd1);
        chk("timeout_estado", 32'(dut.estado), 32'(S_EXPULSION));
        tick();
        chk("timeout_error_1ciclo", 32'(error_lectura), 32'd0);
        chk("timeout_expulsar_sigue", 32'(expulsar_tarjeta), 32'd1);
        sensor_tarjeta = 1'b0;
        tick();
        chk("timeout_espera", 32'(dut.estado), 32'(S_ESPERA));
        chk("timeout_expulsar_0", 32'(expulsar_tarjeta), 32'd0);

        // Reset while presenting a card.
        insertar();
        enviar_bits(16'h1234, 16);
        chk("rstent_recibida", 32'(tarjeta_recibida), 32'd1);
        chk("rstent_numero", 32'(numero_tarjeta), 32'h1234);
        e0 = err_pulsos;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        sensor_tarjeta = 1'b0;
        chk("rstent_estado", 32'(dut.estado), 32'(S_ESPERA));
        chk("rstent_salidas", {28'd0, tarjeta_recibida, expulsar_tarjeta, error_lectura, |numero_tarjeta}, 32'd0);
        repeat (2) tick();
        chk("rstent_sin_error", 32'(err_pulsos - e0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lector_tarjeta.md
LECTOR_TARJETA -- requirements
Module: lector_tarjeta

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive sampled-high cycles of sensor_tarjeta required to accept a card.
REQ-002 Parameter NUM_BITS, default 16: card-number length in bits.
REQ-003 Parameter TIMEOUT, default 32: maximum cycles between bit_valido strobes while reading.
REQ-004 clk  input  1  single clock; all logic samples on the rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
REQ-006 sensor_tarjeta  input  1  raw card-present sensor; 1 = card in slot.
REQ-007 dato_serial  input  1  serial card-number bit, valid when bit_valido=1.
REQ-008 bit_valido  input  1  one-cycle strobe qualifying dato_serial.
REQ-009 fin  input  1  controller done; 1 = transaction finished, release card.
REQ-010 tarjeta_recibida  output  1  level; 1 = valid card number presented to the controller.
REQ-011 numero_tarjeta  output  NUM_BITS  assembled card number; stable while tarjeta_recibida=1.
REQ-012 expulsar_tarjeta  output  1  level; 1 = eject motor on.
REQ-013 error_lectura  output  1  one-cycle pulse on an aborted read.

Function
REQ-014 The block SHALL implement five states: ESPERA, ANTIREBOTE, LECTURA, ENTREGA, EXPULSION.
REQ-015 ESPERA: sensor_tarjeta=1 SHALL move the block to ANTIREBOTE with the debounce counter set to 1; otherwise it SHALL stay in ESPERA.
REQ-016 ANTIREBOTE: sensor=1 SHALL increment the counter, and reaching DEBOUNCE_CYCLES SHALL move the block to LECTURA with the bit counter at 0 and the shift register cleared; sensor=0 SHALL return the block to ESPERA with no error.
REQ-017 LECTURA: each cycle with bit_valido=1 SHALL shift dato_serial in MSB-first (shift left, new bit into LSB) and SHALL increment the bit counter.
REQ-018 After the NUM_BITS-th accepted bit, the next state SHALL be ENTREGA; bit_valido in any state other than LECTURA SHALL be ignored.
REQ-019 LECTURA: the idle counter SHALL reset on each bit_valido; reaching TIMEOUT idle cycles SHALL pulse error_lectura and move the block to EXPULSION.
REQ-020 LECTURA: sensor_tarjeta=0 SHALL pulse error_lectura and move the block to ESPERA, discarding partial bits; this takes priority over a simultaneous bit_valido.
REQ-021 ENTREGA: tarjeta_recibida SHALL be 1, starting the first cycle after the last bit, and numero_tarjeta SHALL hold the assembled value.
REQ-022 ENTREGA: the block SHALL stay in ENTREGA until fin=1, then move to EXPULSION, with tarjeta_recibida=0 from that cycle.
REQ-023 ENTREGA: sensor_tarjeta=0 before fin SHALL pulse error_lectura, drop tarjeta_recibida, and return the block to ESPERA.
REQ-024 EXPULSION: expulsar_tarjeta SHALL be 1 until sensor_tarjeta is sampled 0, then the block SHALL move to ESPERA with expulsar_tarjeta=0.
REQ-025 fin outside ENTREGA SHALL be ignored.
REQ-026 numero_tarjeta SHALL hold its last value after ENTREGA until the next entry into LECTURA clears it.
REQ-027 All outputs SHALL be registered; error_lectura SHALL never exceed one cycle per event.
REQ-028 The counters SHALL be sized to reach DEBOUNCE_CYCLES, NUM_BITS and TIMEOUT without wrap-around.

Reset
REQ-029 While reset=0 at a clock edge, the state SHALL be ESPERA, all counters 0, numero_tarjeta all zeros, and tarjeta_recibida, expulsar_tarjeta and error_lectura 0.
REQ-030 Reset SHALL override any state, including mid-LECTURA and ENTREGA, and SHALL produce no error_lectura pulse.

Verification
REQ-031 Normal: sensor=1 for 4 cycles, then 16 bits of 0xA5C3 on bit_valido, then fin=1 -> tarjeta_recibida=1 with numero_tarjeta=16'hA5C3 the cycle after the 16th bit; then expulsar_tarjeta=1 until sensor=0, then ESPERA.
REQ-032 Bounce: sensor=1 for 3 cycles, then 0 -> no transition to LECTURA, error_lectura stays 0.
REQ-033 Removal mid-read: sensor drops after 7 bits -> single error_lectura pulse, tarjeta_recibida stays 0, state ESPERA.
REQ-034 Timeout: after 5 bits, no bit_valido for 32 cycles -> error_lectura pulse, expulsar_tarjeta=1.
REQ-035 Reset mid-ENTREGA: reset=0 for 1 cycle while tarjeta_recibida=1 -> all outputs 0 and state ESPERA the next cycle, no error pulse.
REQ-036 Stray fin: fin=1 in ESPERA and LECTURA -> no effect on state or outputs.
